vram_line_fetch: RTL and testbench

Reads one text row of character codes from the text VRAM read port (port B) into a ping-pong line buffer. A display or text consumer can then index characters by column while the next row is fetched. It sits on the MEMORY_CLK side of the text VRAM, the read-side counterpart of the boot-time VRAM writer, and drives `adb`/`ceb`/`oce` and samples `dout` of the 1024×8 VRAM. The text grid is 60 columns × 17 rows (8×16-pixel cells on 480×272), linear address = row*COLS + col.

---
 rtl/vram_line_fetch_if.sv | 22 ++
 rtl/vram_line_fetch.sv | 144 ++++++++++++++
 tb/tb_vram_line_fetch.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/vram_line_fetch_if.sv
// Text VRAM read-port bundle (port B) between the line fetcher and the 1024x8 VRAM.
// master = fetcher driving address/enables, slave = VRAM returning data.
interface vram_line_fetch_if;
  logic [9:0] vram_adb;
  logic       vram_ceb;
  logic       vram_oce;
  logic [7:0] vram_dout;

  modport master (
    output vram_adb,
    output vram_ceb,
    output vram_oce,
    input  vram_dout
  );

  modport slave (
    input  vram_adb,
    input  vram_ceb,
    input  vram_oce,
    output vram_dout
  );
endinterface

// File: rtl/vram_line_fetch.sv
// Fetches one text row from VRAM port B into a ping-pong line buffer.
// Consumer reads the front half by column while the back half refills.
module vram_line_fetch #(
  parameter int         COLS         = 60,
  parameter int         ROWS         = 17,
  parameter int         READ_LATENCY = 2,
  parameter logic [7:0] BLANK        = 8'h20
) (
  input  logic                      MEMORY_CLK,
  input  logic                      rst_n,
  input  logic                      line_req,
  input  logic [4:0]                line_row,
  output logic                      busy,
  output logic                      line_done,
  output logic                      line_err,
  vram_line_fetch_if.master         vram,
  input  logic [5:0]                rd_col,
  output logic [7:0]                rd_char
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam int         RL     = READ_LATENCY;
  localparam logic [5:0] LAST   = 6'(COLS - 1);
  localparam logic [5:0] ROWS_W = 6'(ROWS);
  localparam logic [6:0] COLS_W = 7'(COLS);
  localparam logic [9:0] COLS10 = 10'(COLS);

  state_t        state;
  state_t        state_nx;
  logic [9:0]    base;
  logic [5:0]    issue_col;
  logic          front_sel;
  logic          err_q;
  logic [RL-1:0] pv;
  logic [5:0]    pc [RL];
  logic [7:0]    line_buf [2][COLS];

  logic          open;
  logic          row_ok;
  logic          accept;
  logic          tail_v;
  logic [5:0]    tail_c;
  logic          last_cap;

  // DONE accepts a new request so back-to-back rows lose no cycle
  assign open     = (state == IDLE) || (state == DONE);
  assign row_ok   = {1'b0, line_row} < ROWS_W;
  assign accept   = open && line_req && row_ok;
  assign tail_v   = pv[RL-1];
  assign tail_c   = pc[RL-1];
  assign last_cap = tail_v && (tail_c == LAST);
  assign line_err = err_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE,
      DONE:  state_nx = accept ? ISSUE : IDLE;
      ISSUE: if (issue_col == LAST) state_nx = DRAIN;
      DRAIN: if (last_cap) state_nx = DONE;
    endcase
  end

  always_comb begin
    vram.vram_adb = '0;
    vram.vram_ceb = 1'b0;
    vram.vram_oce = 1'b0;
    busy          = 1'b0;
    line_done     = 1'b0;
    unique case (state)
      ISSUE: begin
        vram.vram_adb = base + {4'd0, issue_col};
        vram.vram_ceb = 1'b1;
        vram.vram_oce = 1'b1;
        busy          = 1'b1;
      end
      DRAIN: begin
        vram.vram_oce = 1'b1;
        busy          = 1'b1;
      end
      DONE:  line_done = 1'b1;
      IDLE:  ;
    endcase
  end

  always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base      <= '0;
      issue_col <= '0;
      front_sel <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= open && line_req && !row_ok;
      if (accept) begin
        base      <= 10'(line_row) * COLS10;
        issue_col <= '0;
      end else if (state == ISSUE) begin
        issue_col <= issue_col + 6'd1;
      end
      if (state == DONE)
        front_sel <= ~front_sel;
    end
  end

  // One stage per VRAM latency edge; the tail lines up with valid dout
  always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i < RL; i++)
        pc[i] <= '0;
    end else begin
      pv[0] <= (state == ISSUE);
      pc[0] <= issue_col;
      for (int i = 1; i < RL; i++) begin
        pv[i] <= pv[i-1];
        pc[i] <= pc[i-1];
      end
    end
  end

  // Line storage is deliberately left uncleared by reset
  always_ff @(posedge MEMORY_CLK) begin
    if (tail_v)
      line_buf[~front_sel][tail_c] <= vram.vram_dout;
  end

  always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
    if (!rst_n)
      rd_char <= '0;
    else if ({1'b0, rd_col} < COLS_W)
      rd_char <= line_buf[front_sel][rd_col];
    else
      rd_char <= BLANK;
  end

endmodule

// File: tb/tb_vram_line_fetch.sv
// Bench for vram_line_fetch: VRAM model with mem[a]=a[7:0], row-level
// reference model of the two line buffers, randomized rows and columns.
module tb_vram_line_fetch;

  localparam int COLS = 60;
  localparam int ROWS = 17;
  localparam int RL   = 2;

  logic       MEMORY_CLK = 1'b0;
  logic       rst_n;
  logic       line_req;
  logic [4:0] line_row;
  logic       busy;
  logic       line_done;
  logic       line_err;
  logic [5:0] rd_col;
  logic [7:0] rd_char;

  vram_line_fetch_if vif ();

  vram_line_fetch dut (
    .MEMORY_CLK (MEMORY_CLK),
    .rst_n      (rst_n),
    .line_req   (line_req),
    .line_row   (line_row),
    .busy       (busy),
    .line_done  (line_done),
    .line_err   (line_err),
    .vram       (vif.master),
    .rd_col     (rd_col),
    .rd_char    (rd_char)
  );

  always #5 MEMORY_CLK = ~MEMORY_CLK;

  logic [7:0] mem [1024];
  logic [7:0] d1;

  always @(posedge MEMORY_CLK) begin
    if (vif.vram_ceb) d1 <= mem[vif.vram_adb];
    if (vif.vram_oce) vif.vram_dout <= d1;
  end

  int checks;
  int errors;
  int rowbuf [2];
  int front;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_char(input int col);
    if (col >= COLS) return 'h20;
    return (rowbuf[front] * COLS + col) & 255;
  endfunction

  task automatic read_chk(input int col, input string tag);
    @(negedge MEMORY_CLK);
    rd_col = col[5:0];
    @(negedge MEMORY_CLK);
    check(tag, rd_char, exp_char(col));
  endtask

  task automatic reset_outs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, line_done, 0);
    check({tag, "_err"}, line_err, 0);
    check({tag, "_adb"}, vif.vram_adb, 0);
    check({tag, "_ceb"}, vif.vram_ceb, 0);
    check({tag, "_oce"}, vif.vram_oce, 0);
    check({tag, "_rdchar"}, rd_char, 0);
  endtask

  task automatic fetch(input int row, input int abort_at);
    int n, done_n, bad_adb, bad_busy, last_adb, pend;
    bit pend_v, on;
    n = 0; done_n = 0; bad_adb = 0; bad_busy = 0;
    last_adb = -1; pend = 0; pend_v = 0;
    @(negedge MEMORY_CLK);
    line_req = 1'b1;
    line_row = row[4:0];
    while (done_n == 0 && n < 200) begin
      @(negedge MEMORY_CLK);
      n++;
      if (n == 1) line_req = 1'b0;
      if (pend_v) check("rd_during", rd_char, pend);
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        reset_outs("abort");
        @(negedge MEMORY_CLK);
        @(negedge MEMORY_CLK);
        rst_n = 1'b1;
        front = 0;
        rowbuf[1] = -1;
        return;
      end
      on = (n <= COLS);
      if (vif.vram_ceb !== on) bad_adb++;
      if (on && vif.vram_adb !== 10'(row * COLS + n - 1)) bad_adb++;
      if (n == COLS) last_adb = int'(vif.vram_adb);
      if (busy !== (n <= COLS + RL)) bad_busy++;
      if (vif.vram_oce !== (n <= COLS + RL)) bad_busy++;
      if (line_done) done_n = n;
      rd_col = 6'($urandom_range(0, 63));
      pend_v = (rowbuf[front] >= 0);
      pend = exp_char(int'(rd_col));
    end
    check("done_cycle", done_n, COLS + RL + 1);
    check("adb_seq_bad", bad_adb, 0);
    check("busy_oce_bad", bad_busy, 0);
    check("last_adb", last_adb, row * COLS + COLS - 1);
    front ^= 1;
    rowbuf[front] = row;
    @(negedge MEMORY_CLK);
    if (pend_v) check("rd_swap", rd_char, pend);
  endtask

  task automatic err_req(input int row);
    @(negedge MEMORY_CLK);
    line_req = 1'b1;
    line_row = row[4:0];
    @(negedge MEMORY_CLK);
    line_req = 1'b0;
    check("err_pulse", line_err, 1);
    check("err_busy", busy, 0);
    check("err_ceb", vif.vram_ceb, 0);
    @(negedge MEMORY_CLK);
    check("err_clear", line_err, 0);
  endtask

  initial begin
    int t, prev, d, acc, nd;
    checks = 0; errors = 0;
    rowbuf[0] = -1; rowbuf[1] = -1; front = 0;
    for (int a = 0; a < 1024; a++) mem[a] = a[7:0];
    rst_n = 1'b0; line_req = 1'b0; line_row = '0; rd_col = '0;
    #12;
    reset_outs("reset");
    @(negedge MEMORY_CLK);
    rst_n = 1'b1;

    fetch(0, 0);
    read_chk(5, "row0_col5");
    fetch(16, 0);
    read_chk(59, "row16_col59");
    read_chk(60, "row16_col60");
    read_chk(63, "row16_col63");

    err_req(17);
    err_req($urandom_range(18, 31));
    read_chk($urandom_range(0, 59), "after_err");

    fetch(3, 0);
    read_chk(0, "row3_col0");
    fetch(4, 0);
    read_chk(0, "row4_col0");

    repeat (4) begin
      fetch($urandom_range(0, ROWS - 1), 0);
      read_chk($urandom_range(0, 63), "rand_col");
    end

    if (front != 0) fetch($urandom_range(0, ROWS - 1), 0);
    fetch($urandom_range(0, ROWS - 1), 30);
    nd = 0;
    repeat (80) begin
      @(negedge MEMORY_CLK);
      if (line_done) nd++;
    end
    check("no_done_after_abort", nd, 0);
    read_chk($urandom_range(0, 59), "abort_front0");
    read_chk($urandom_range(0, 59), "abort_front0b");

    @(negedge MEMORY_CLK);
    acc = $urandom_range(0, ROWS - 1);
    line_row = acc[4:0];
    line_req = 1'b1;
    prev = 0; d = 0; t = 0;
    while (d < 3 && t < 400) begin
      @(negedge MEMORY_CLK);
      t++;
      if (line_done) begin
        check("b2b_gap", t - prev, COLS + RL + 1);
        prev = t;
        d++;
        front ^= 1;
        rowbuf[front] = acc;
        if (d == 3) line_req = 1'b0;
        else begin
          acc = $urandom_range(0, ROWS - 1);
          line_row = acc[4:0];
        end
      end else begin
        line_row = 5'($urandom_range(0, ROWS - 1));
      end
    end
    line_req = 1'b0;
    check("b2b_count", d, 3);
    read_chk($urandom_range(0, 59), "b2b_col");
    read_chk(0, "b2b_col0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
